// File: rtl/branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_unit_pkg
// Shared instruction definitions for the 8-bit two-accumulator pipeline:
// opcode constants, architectural flag bit positions inside the packed
// {CA,CB,ZA,ZB,NA,NB} flag vector, opcode group helpers that tell which
// flags an ALU opcode writes, and the branch condition encoding.
// ---------------------------------------------------------------------------
package branch_unit_pkg;

  // ALU opcodes, accumulator A
  localparam logic [5:0] OP_ADDA  = 6'h01;
  localparam logic [5:0] OP_ADDCA = 6'h02;
  localparam logic [5:0] OP_SUBA  = 6'h03;
  localparam logic [5:0] OP_SUBCA = 6'h04;
  localparam logic [5:0] OP_ANDA  = 6'h05;
  localparam logic [5:0] OP_ANDCA = 6'h06;
  localparam logic [5:0] OP_ORA   = 6'h07;
  localparam logic [5:0] OP_ORCA  = 6'h08;
  localparam logic [5:0] OP_ASLA  = 6'h09;
  localparam logic [5:0] OP_ASRA  = 6'h0A;

  // ALU opcodes, accumulator B
  localparam logic [5:0] OP_ADDB  = 6'h0B;
  localparam logic [5:0] OP_ADDCB = 6'h0C;
  localparam logic [5:0] OP_SUBB  = 6'h0D;
  localparam logic [5:0] OP_SUBCB = 6'h0E;
  localparam logic [5:0] OP_ANDB  = 6'h0F;
  localparam logic [5:0] OP_ANDCB = 6'h10;
  localparam logic [5:0] OP_ORB   = 6'h11;
  localparam logic [5:0] OP_ORCB  = 6'h12;

  // Control flow
  localparam logic [5:0] OP_JMP   = 6'h18;
  localparam logic [5:0] OP_BAEQ  = 6'h19;
  localparam logic [5:0] OP_BANE  = 6'h1A;
  localparam logic [5:0] OP_BACS  = 6'h1B;
  localparam logic [5:0] OP_BACC  = 6'h1C;
  localparam logic [5:0] OP_BAMI  = 6'h1D;
  localparam logic [5:0] OP_BAPL  = 6'h1E;
  localparam logic [5:0] OP_BBEQ  = 6'h1F;
  localparam logic [5:0] OP_BBNE  = 6'h20;
  localparam logic [5:0] OP_BBCS  = 6'h21;
  localparam logic [5:0] OP_BBCC  = 6'h22;
  localparam logic [5:0] OP_BBMI  = 6'h23;
  localparam logic [5:0] OP_BBPL  = 6'h24;

  // Bit positions in the packed flag vector {CA,CB,ZA,ZB,NA,NB}
  localparam int FLAG_NB = 0;
  localparam int FLAG_NA = 1;
  localparam int FLAG_ZB = 2;
  localparam int FLAG_ZA = 3;
  localparam int FLAG_CB = 4;
  localparam int FLAG_CA = 5;

  typedef enum logic [2:0] {
    COND_EQ,
    COND_NE,
    COND_CS,
    COND_CC,
    COND_MI,
    COND_PL
  } cond_e;

  // Arithmetic A ops: write CA, ZA, NA
  function automatic logic op_wr_a_czn(input logic [5:0] op);
    return op inside {OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA};
  endfunction

  // Logic/shift A ops: write ZA, NA only, carry is preserved
  function automatic logic op_wr_a_zn(input logic [5:0] op);
    return op inside {OP_ANDA, OP_ANDCA, OP_ORA, OP_ORCA, OP_ASLA, OP_ASRA};
  endfunction

  function automatic logic op_wr_b_czn(input logic [5:0] op);
    return op inside {OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB};
  endfunction

  function automatic logic op_wr_b_zn(input logic [5:0] op);
    return op inside {OP_ANDB, OP_ANDCB, OP_ORB, OP_ORCB};
  endfunction

  function automatic logic op_wr_a(input logic [5:0] op);
    return op_wr_a_czn(op) | op_wr_a_zn(op);
  endfunction

  function automatic logic op_wr_b(input logic [5:0] op);
    return op_wr_b_czn(op) | op_wr_b_zn(op);
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// ---------------------------------------------------------------------------
// branch_unit_if
// Bundle between the pipeline (EX flag producer, ID branch source, PC/IF
// control) and the branch unit.
//   master : pipeline side, drives EX/ID info, receives stall/redirect
//   slave  : branch unit side
// EX side : iAluValid, iAluInstSel, iBCA/iBCB/iBAZ/iBBZ/iBAN/iBBN
// ID side : iBrValid, iBrInstSel, iBrTarget
// Results : oStall, oRedirect, oFlush, oPCTarget, oFlags, statistics counters
// ---------------------------------------------------------------------------
interface branch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              iAluValid;
  logic [5:0]        iAluInstSel;
  logic              iBCA;
  logic              iBCB;
  logic              iBAZ;
  logic              iBBZ;
  logic              iBAN;
  logic              iBBN;
  logic              iBrValid;
  logic [5:0]        iBrInstSel;
  logic [ADDR_W-1:0] iBrTarget;

  logic              oStall;
  logic              oRedirect;
  logic              oFlush;
  logic [ADDR_W-1:0] oPCTarget;
  logic [5:0]        oFlags;
  logic [CNT_W-1:0]  oTakenCnt;
  logic [CNT_W-1:0]  oNotTakenCnt;
  logic [CNT_W-1:0]  oStallCnt;

  modport master (
    output iAluValid, iAluInstSel, iBCA, iBCB, iBAZ, iBBZ, iBAN, iBBN,
    output iBrValid, iBrInstSel, iBrTarget,
    input  oStall, oRedirect, oFlush, oPCTarget, oFlags,
    input  oTakenCnt, oNotTakenCnt, oStallCnt
  );

  modport slave (
    input  iAluValid, iAluInstSel, iBCA, iBCB, iBAZ, iBBZ, iBAN, iBBN,
    input  iBrValid, iBrInstSel, iBrTarget,
    output oStall, oRedirect, oFlush, oPCTarget, oFlags,
    output oTakenCnt, oNotTakenCnt, oStallCnt
  );
endinterface

// File: rtl/branch_unit_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Purely combinational branch decode and condition evaluation.
//   opcode    : instruction in ID
//   flags     : architectural flags {CA,CB,ZA,ZB,NA,NB}
//   is_branch : JMP or any conditional branch
//   is_cond   : conditional branch (BAxx / BBxx)
//   acc_sel   : 0 = tests accumulator A flags, 1 = accumulator B flags
//   taken     : branch would be taken on the given flags (JMP always)
// ---------------------------------------------------------------------------
module branch_cond
  import branch_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] flags,
  output logic       is_branch,
  output logic       is_cond,
  output logic       acc_sel,
  output logic       taken
);

  cond_e cond;
  logic  c_sel;
  logic  z_sel;
  logic  n_sel;

  always_comb begin
    is_cond = 1'b1;
    acc_sel = 1'b0;
    cond    = COND_EQ;
    case (opcode)
      OP_BAEQ: cond = COND_EQ;
      OP_BANE: cond = COND_NE;
      OP_BACS: cond = COND_CS;
      OP_BACC: cond = COND_CC;
      OP_BAMI: cond = COND_MI;
      OP_BAPL: cond = COND_PL;
      OP_BBEQ: begin cond = COND_EQ; acc_sel = 1'b1; end
      OP_BBNE: begin cond = COND_NE; acc_sel = 1'b1; end
      OP_BBCS: begin cond = COND_CS; acc_sel = 1'b1; end
      OP_BBCC: begin cond = COND_CC; acc_sel = 1'b1; end
      OP_BBMI: begin cond = COND_MI; acc_sel = 1'b1; end
      OP_BBPL: begin cond = COND_PL; acc_sel = 1'b1; end
      default: is_cond = 1'b0;
    endcase
  end

  assign is_branch = is_cond | (opcode == OP_JMP);

  assign c_sel = acc_sel ? flags[FLAG_CB] : flags[FLAG_CA];
  assign z_sel = acc_sel ? flags[FLAG_ZB] : flags[FLAG_ZA];
  assign n_sel = acc_sel ? flags[FLAG_NB] : flags[FLAG_NA];

  always_comb begin
    taken = 1'b0;
    if (opcode == OP_JMP) begin
      taken = 1'b1;
    end else if (is_cond) begin
      case (cond)
        COND_EQ: taken = z_sel;
        COND_NE: taken = ~z_sel;
        COND_CS: taken = c_sel;
        COND_CC: taken = ~c_sel;
        COND_MI: taken = n_sel;
        COND_PL: taken = ~n_sel;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
// Consumes ALU condition flags, resolves JMP / conditional branches in ID,
// stalls ID one cycle on a flag read-after-write hazard and issues a
// one-cycle PC redirect + IF/ID flush for taken branches. Saturating
// taken / not-taken / stall counters are kept for debug.
//   iClock   : rising-edge clock
//   iReset_n : asynchronous active-low reset
//   bus      : branch_unit_if slave (EX flags, ID branch, redirect/stall out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | evaluating branches in ID, may stall on a flag hazard
// ST_REDIR | redirect/flush cycle; ID holds wrong-path code and is ignored
// ---------------------------------------------------------------------------
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic         iClock,
  input  logic         iReset_n,
  branch_unit_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [5:0]        flags_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  taken_q;
  logic [CNT_W-1:0]  not_taken_q;
  logic [CNT_W-1:0]  stall_q;

  logic is_branch;
  logic is_cond;
  logic acc_sel;
  logic br_taken;
  logic ex_wr_a;
  logic ex_wr_b;
  logic hazard;
  logic in_idle;
  logic stall;
  logic eval;

  branch_cond u_cond (
    .opcode    (bus.iBrInstSel),
    .flags     (flags_q),
    .is_branch (is_branch),
    .is_cond   (is_cond),
    .acc_sel   (acc_sel),
    .taken     (br_taken)
  );

  // Flag register: each opcode group only touches its own flags, so a
  // logic op on A keeps CA and a B op never disturbs the A flags.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      flags_q <= '0;
    end else if (bus.iAluValid) begin
      if (op_wr_a_czn(bus.iAluInstSel)) begin
        flags_q[FLAG_CA] <= bus.iBCA;
      end
      if (op_wr_a(bus.iAluInstSel)) begin
        flags_q[FLAG_ZA] <= bus.iBAZ;
        flags_q[FLAG_NA] <= bus.iBAN;
      end
      if (op_wr_b_czn(bus.iAluInstSel)) begin
        flags_q[FLAG_CB] <= bus.iBCB;
      end
      if (op_wr_b(bus.iAluInstSel)) begin
        flags_q[FLAG_ZB] <= bus.iBBZ;
        flags_q[FLAG_NB] <= bus.iBBN;
      end
    end
  end

  // A conditional branch must wait when EX is about to rewrite any flag of
  // the accumulator it tests; the bubble inserted next cycle clears it.
  assign ex_wr_a = bus.iAluValid & op_wr_a(bus.iAluInstSel);
  assign ex_wr_b = bus.iAluValid & op_wr_b(bus.iAluInstSel);
  assign hazard  = bus.iBrValid & is_cond & (acc_sel ? ex_wr_b : ex_wr_a);

  assign in_idle = (state_q == ST_IDLE);
  assign stall   = in_idle & hazard;
  assign eval    = in_idle & bus.iBrValid & is_branch & ~hazard;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (eval && br_taken) state_d = ST_REDIR;
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Target is only loaded on a taken decision and otherwise holds.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      pc_q <= '0;
    end else if (eval && br_taken) begin
      pc_q <= bus.iBrTarget;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      taken_q     <= '0;
      not_taken_q <= '0;
      stall_q     <= '0;
    end else begin
      if (eval && br_taken && (taken_q != '1)) begin
        taken_q <= taken_q + CNT_W'(1);
      end
      if (eval && !br_taken && (not_taken_q != '1)) begin
        not_taken_q <= not_taken_q + CNT_W'(1);
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // Stall is combinational from ID/EX; hold it low while reset is applied
  // so the pipeline is not frozen by stale opcodes during reset.
  assign bus.oStall       = stall & iReset_n;
  assign bus.oRedirect    = (state_q == ST_REDIR);
  assign bus.oFlush       = (state_q == ST_REDIR);
  assign bus.oPCTarget    = pc_q;
  assign bus.oFlags       = flags_q;
  assign bus.oTakenCnt    = taken_q;
  assign bus.oNotTakenCnt = not_taken_q;
  assign bus.oStallCnt    = stall_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  import branch_unit_pkg::*;

  localparam int AW = 10;
  localparam int CW = 16;
  localparam int CMAX = 65535;

  logic iClock = 1'b0;
  logic iReset_n = 1'b0;

  branch_unit_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  branch_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .bus      (bus)
  );

  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;

  // current stimulus
  bit          cur_av;
  logic [5:0]  cur_aop;
  logic [5:0]  cur_af;
  bit          cur_bv;
  logic [5:0]  cur_bop;
  logic [AW-1:0] cur_tgt;

  // reference model
  logic [5:0]    m_flags;
  bit            m_redir;
  logic [AW-1:0] m_tgt;
  int            m_taken;
  int            m_nt;
  int            m_stall;

  // flags written by an ALU opcode, as a mask in {CA,CB,ZA,ZB,NA,NB} order
  function automatic logic [5:0] wr_mask(input logic [5:0] op);
    case (op)
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA:                   return 6'b101010;
      OP_ANDA, OP_ANDCA, OP_ORA, OP_ORCA, OP_ASLA, OP_ASRA:   return 6'b001010;
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB:                   return 6'b010101;
      OP_ANDB, OP_ANDCB, OP_ORB, OP_ORCB:                     return 6'b000101;
      default:                                                return 6'b000000;
    endcase
  endfunction

  function automatic bit m_is_cond(input logic [5:0] op);
    return (op >= 6'h19) && (op <= 6'h24);
  endfunction

  function automatic bit m_is_branch(input logic [5:0] op);
    return (op >= 6'h18) && (op <= 6'h24);
  endfunction

  function automatic logic [5:0] acc_mask(input logic [5:0] op);
    return (op >= 6'h1F) ? 6'b010101 : 6'b101010;
  endfunction

  // branch opcodes come in runs of six: EQ NE CS CC MI PL, first A then B
  function automatic bit model_taken(input logic [5:0] op, input logic [5:0] f);
    bit is_b;
    int k;
    bit c, z, n;
    if (op == 6'h18) return 1'b1;
    is_b = (op >= 6'h1F);
    k = is_b ? int'(op) - 'h1F : int'(op) - 'h19;
    c = is_b ? f[4] : f[5];
    z = is_b ? f[2] : f[3];
    n = is_b ? f[0] : f[1];
    case (k)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      default: return !n;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic bit exp_stall();
    return !m_redir && cur_bv && m_is_cond(cur_bop) && cur_av &&
           ((wr_mask(cur_aop) & acc_mask(cur_bop)) != 6'b0);
  endfunction

  task automatic model_reset();
    m_flags = '0; m_redir = 1'b0; m_tgt = '0;
    m_taken = 0; m_nt = 0; m_stall = 0;
  endtask

  task automatic drive(input bit av, input logic [5:0] aop, input logic [5:0] af,
                       input bit bv, input logic [5:0] bop, input logic [AW-1:0] tgt);
    cur_av = av; cur_aop = aop; cur_af = af;
    cur_bv = bv; cur_bop = bop; cur_tgt = tgt;
    bus.iAluValid = av; bus.iAluInstSel = aop;
    bus.iBCA = af[5]; bus.iBCB = af[4]; bus.iBAZ = af[3];
    bus.iBBZ = af[2]; bus.iBAN = af[1]; bus.iBBN = af[0];
    bus.iBrValid = bv; bus.iBrInstSel = bop; bus.iBrTarget = tgt;
    #1;
  endtask

  // advance one clock, updating the model from the pre-edge situation
  task automatic tick();
    logic [5:0] mk;
    if (m_redir) begin
      m_redir = 1'b0;
    end else if (cur_bv && m_is_branch(cur_bop)) begin
      if (exp_stall()) m_stall = sat(m_stall);
      else if (model_taken(cur_bop, m_flags)) begin
        m_tgt = cur_tgt; m_redir = 1'b1; m_taken = sat(m_taken);
      end else m_nt = sat(m_nt);
    end
    if (cur_av) begin
      mk = wr_mask(cur_aop);
      m_flags = (m_flags & ~mk) | (cur_af & mk);
    end
    @(posedge iClock);
    #1;
  endtask

  task automatic reset_dut();
    iReset_n = 1'b0;
    drive(0, 6'h00, 6'h00, 0, 6'h00, '0);
    @(posedge iClock);
    #1;
    iReset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if ({bus.oRedirect, bus.oFlush} !== 2'b00) begin errors++;
      $display("FAIL reset_redirect got %b%b exp 00", bus.oRedirect, bus.oFlush); end
    checks++; if (bus.oFlags !== 6'h00) begin errors++;
      $display("FAIL reset_flags got %h exp 00", bus.oFlags); end
    checks++; if (bus.oPCTarget !== '0 || bus.oTakenCnt !== '0 || bus.oNotTakenCnt !== '0 || bus.oStallCnt !== '0) begin errors++;
      $display("FAIL reset_regs pc %h cnt %h %h %h exp 0", bus.oPCTarget, bus.oTakenCnt, bus.oNotTakenCnt, bus.oStallCnt); end
    // reset mid-REDIR
    drive(0, 6'h00, 6'h00, 1, OP_JMP, 10'h123);
    tick();
    checks++; if (bus.oRedirect !== 1'b1 || bus.oPCTarget !== 10'h123) begin errors++;
      $display("FAIL pre_reset_redirect got %b %h exp 1 123", bus.oRedirect, bus.oPCTarget); end
    drive(1, OP_ADDA, 6'h3F, 1, OP_BAEQ, 10'h055);
    iReset_n = 1'b0;
    #1;
    checks++; if ({bus.oRedirect, bus.oFlush, bus.oStall} !== 3'b000) begin errors++;
      $display("FAIL reset_abort got redir %b flush %b stall %b exp 000", bus.oRedirect, bus.oFlush, bus.oStall); end
    checks++; if (bus.oPCTarget !== '0 || bus.oTakenCnt !== '0 || bus.oFlags !== 6'h00) begin errors++;
      $display("FAIL reset_abort_regs pc %h taken %h flags %h exp 0", bus.oPCTarget, bus.oTakenCnt, bus.oFlags); end
    @(posedge iClock); #1;
    checks++; if (bus.oStall !== 1'b0) begin errors++;
      $display("FAIL stall_in_reset got %b exp 0", bus.oStall); end
    drive(0, 6'h00, 6'h00, 0, 6'h00, '0);
    iReset_n = 1'b1;
    model_reset();
    tick();
    checks++; if (bus.oRedirect !== 1'b0 || bus.oFlags !== 6'h00) begin errors++;
      $display("FAIL post_reset_idle redir %b flags %h exp 0 00", bus.oRedirect, bus.oFlags); end
  endtask

  task automatic test_adda_bacs();
    reset_dut();
    drive(1, OP_ADDA, 6'b101000, 0, 6'h00, '0);
    tick();
    checks++; if (bus.oFlags !== 6'b101000) begin errors++;
      $display("FAIL adda_flags got %b exp 101000", bus.oFlags); end
    drive(0, 6'h00, 6'h00, 1, OP_BACS, 10'h005);
    checks++; if (bus.oStall !== 1'b0) begin errors++;
      $display("FAIL bacs_stall got %b exp 0", bus.oStall); end
    tick();
    checks++; if (bus.oRedirect !== 1'b1 || bus.oFlush !== 1'b1 || bus.oPCTarget !== 10'h005) begin errors++;
      $display("FAIL bacs_redirect got %b %b %h exp 1 1 005", bus.oRedirect, bus.oFlush, bus.oPCTarget); end
    checks++; if (bus.oTakenCnt !== 16'd1) begin errors++;
      $display("FAIL bacs_taken_cnt got %0d exp 1", bus.oTakenCnt); end
  endtask

  task automatic test_hazard_stall();
    reset_dut();
    drive(1, OP_ANDB, 6'b000100, 1, OP_BBEQ, 10'h02A);
    checks++; if (bus.oStall !== 1'b1) begin errors++;
      $display("FAIL hazard_stall got %b exp 1", bus.oStall); end
    tick();
    checks++; if (bus.oStallCnt !== 16'd1 || bus.oRedirect !== 1'b0 || bus.oFlags !== 6'b000100) begin errors++;
      $display("FAIL hazard_after stallcnt %0d redir %b flags %b exp 1 0 000100", bus.oStallCnt, bus.oRedirect, bus.oFlags); end
    drive(0, 6'h00, 6'h00, 1, OP_BBEQ, 10'h02A);
    checks++; if (bus.oStall !== 1'b0) begin errors++;
      $display("FAIL hazard_bubble_stall got %b exp 0", bus.oStall); end
    tick();
    checks++; if (bus.oRedirect !== 1'b1 || bus.oPCTarget !== 10'h02A || bus.oTakenCnt !== 16'd1) begin errors++;
      $display("FAIL hazard_resolve redir %b pc %h taken %0d exp 1 02a 1", bus.oRedirect, bus.oPCTarget, bus.oTakenCnt); end
    drive(0, 6'h00, 6'h00, 0, 6'h00, '0);
    tick();
    checks++; if (bus.oRedirect !== 1'b0 || bus.oPCTarget !== 10'h02A) begin errors++;
      $display("FAIL redirect_one_cycle redir %b pc %h exp 0 02a", bus.oRedirect, bus.oPCTarget); end
  endtask

  task automatic test_other_acc();
    reset_dut();
    drive(1, OP_ADDA, 6'b100000, 0, 6'h00, '0);
    tick();
    // ORA result 0x7F: Z=0 N=0; carry input deliberately 0 to show CA is kept
    drive(1, OP_ORA, 6'b000000, 1, OP_BBMI, 10'h077);
    checks++; if (bus.oStall !== 1'b0) begin errors++;
      $display("FAIL ora_bbmi_stall got %b exp 0", bus.oStall); end
    tick();
    checks++; if (bus.oNotTakenCnt !== 16'd1 || bus.oRedirect !== 1'b0) begin errors++;
      $display("FAIL bbmi_not_taken ntcnt %0d redir %b exp 1 0", bus.oNotTakenCnt, bus.oRedirect); end
    checks++; if (bus.oFlags !== 6'b100000) begin errors++;
      $display("FAIL ora_keeps_ca got %b exp 100000", bus.oFlags); end
  endtask

  task automatic test_jmp_redir_ignore();
    reset_dut();
    drive(1, OP_SUBA, 6'b001000, 0, 6'h00, '0);
    tick();
    drive(0, 6'h00, 6'h00, 1, OP_JMP, 10'h3FF);
    tick();
    checks++; if (bus.oRedirect !== 1'b1 || bus.oPCTarget !== 10'h3FF) begin errors++;
      $display("FAIL jmp_redirect got %b %h exp 1 3ff", bus.oRedirect, bus.oPCTarget); end
    drive(1, OP_ADDA, 6'b000000, 1, OP_BAEQ, 10'h011);
    checks++; if (bus.oStall !== 1'b0) begin errors++;
      $display("FAIL redir_no_stall got %b exp 0", bus.oStall); end
    tick();
    checks++; if (bus.oRedirect !== 1'b0 || bus.oPCTarget !== 10'h3FF) begin errors++;
      $display("FAIL baeq_ignored redir %b pc %h exp 0 3ff", bus.oRedirect, bus.oPCTarget); end
    checks++; if (bus.oTakenCnt !== 16'd1 || bus.oNotTakenCnt !== 16'd0 || bus.oStallCnt !== 16'd0) begin errors++;
      $display("FAIL redir_counts got %0d %0d %0d exp 1 0 0", bus.oTakenCnt, bus.oNotTakenCnt, bus.oStallCnt); end
  endtask

  task automatic test_random();
    logic [5:0] ops [0:32];
    logic [5:0] aop, bop;
    bit exp_s;
    reset_dut();
    for (int i = 0; i < 33; i++) ops[i] = 6'(i + 1);
    ops[31] = 6'h00;
    ops[32] = 6'h3F;
    for (int n = 0; n < 600; n++) begin
      aop = ops[$urandom_range(0, 32)];
      bop = ($urandom_range(0, 3) != 0) ? 6'(6'h18 + $urandom_range(0, 12)) : ops[$urandom_range(0, 32)];
      drive(1'($urandom_range(0, 1)), aop, 6'($urandom),
            1'($urandom_range(0, 3) != 0), bop, AW'($urandom));
      exp_s = exp_stall();
      checks++; if (bus.oStall !== exp_s) begin errors++;
        $display("FAIL rnd_stall n=%0d got %b exp %b", n, bus.oStall, exp_s); end
      tick();
      checks++; if (bus.oRedirect !== m_redir || bus.oFlush !== m_redir || bus.oPCTarget !== m_tgt) begin errors++;
        $display("FAIL rnd_redirect n=%0d got %b %b %h exp %b %h", n, bus.oRedirect, bus.oFlush, bus.oPCTarget, m_redir, m_tgt); end
      checks++; if (bus.oFlags !== m_flags) begin errors++;
        $display("FAIL rnd_flags n=%0d got %b exp %b", n, bus.oFlags, m_flags); end
      checks++; if (int'(bus.oTakenCnt) != m_taken || int'(bus.oNotTakenCnt) != m_nt || int'(bus.oStallCnt) != m_stall) begin errors++;
        $display("FAIL rnd_counts n=%0d got %0d %0d %0d exp %0d %0d %0d", n, bus.oTakenCnt, bus.oNotTakenCnt, bus.oStallCnt, m_taken, m_nt, m_stall); end
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    drive(0, 6'h00, 6'h00, 1, OP_BAEQ, 10'h001);
    repeat (16'hFFFE) tick();
    checks++; if (bus.oNotTakenCnt !== 16'hFFFE || int'(bus.oNotTakenCnt) != m_nt) begin errors++;
      $display("FAIL sat_preload got %h exp fffe", bus.oNotTakenCnt); end
    repeat (2) tick();
    checks++; if (bus.oNotTakenCnt !== 16'hFFFF) begin errors++;
      $display("FAIL sat_hold got %h exp ffff", bus.oNotTakenCnt); end
    checks++; if (bus.oTakenCnt !== 16'h0 || bus.oRedirect !== 1'b0) begin errors++;
      $display("FAIL sat_no_taken got %h %b exp 0 0", bus.oTakenCnt, bus.oRedirect); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_adda_bacs();
    test_hazard_stall();
    test_other_acc();
    test_jmp_redir_ignore();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Consumer side of the ALU flag interface in the 8-bit two-accumulator pipeline. Latches the six condition flags (carry, zero, negative for A and B) produced by the ALU, resolves JMP and conditional branch opcodes held in ID, stalls ID for one cycle on a flag read-after-write hazard, and issues a one-cycle PC redirect plus IF/ID flush when a branch is taken. Keeps saturating taken/not-taken/stall counters for debug.

## Interface
- ADDR_W, 10, width of PC / branch target
- CNT_W, 16, width of each statistics counter
- iClock  in  1  single clock, rising edge
- iReset_n  in  1  asynchronous, active-low reset
- iAluValid  in  1  EX holds a valid ALU instruction this cycle
- iAluInstSel  in  6  opcode of the instruction in EX
- iBCA, iBCB, iBAZ, iBBZ, iBAN, iBBN  in  1 each  ALU flag outputs for the EX instruction
- iBrValid  in  1  ID holds a valid instruction
- iBrInstSel  in  6  opcode of the instruction in ID
- iBrTarget  in  ADDR_W  absolute target of the ID instruction
- oStall  out  1  hold IF/ID, bubble into EX (combinational)
- oRedirect  out  1  load PC from oPCTarget (registered)
- oFlush  out  1  squash IF/ID contents (registered, equals oRedirect)
- oPCTarget  out  ADDR_W  redirect address (registered)
- oFlags  out  6  {CA,CB,ZA,ZB,NA,NB} architectural flags
- oTakenCnt, oNotTakenCnt, oStallCnt  out  CNT_W each  saturating counters

## Operation
- Opcodes from shared defines: JMP 0x18; BAEQ 0x19, BANE 0x1A, BACS 0x1B, BACC 0x1C, BAMI 0x1D, BAPL 0x1E, BBEQ 0x1F, BBNE 0x20, BBCS 0x21, BBCC 0x22, BBMI 0x23, BBPL 0x24.
- Flag write (clock edge, iAluValid=1): A-group ADDA/ADDCA/SUBA/SUBCA write CA,ZA,NA; ANDA/ANDCA/ORA/ORCA/ASLA/ASRA write ZA,NA only (CA kept). B-group ADDB/ADDCB/SUBB/SUBCB write CB,ZB,NB; ANDB/ANDCB/ORB/ORCB write ZB,NB. All other opcodes: flags unchanged.
- Conditions: EQ=Z, NE=!Z, CS=C, CC=!C, MI=N, PL=!N on the named accumulator; JMP always taken.
- Hazard: iBrValid, ID opcode is a conditional branch on accumulator X, iAluValid, EX opcode writes any flag of X -> oStall=1, no decision this cycle. JMP never stalls. Branch on A with B-group in EX does not stall.
- States: IDLE, REDIR.
  - IDLE, branch in ID, no hazard: evaluate on registered oFlags. Taken -> latch iBrTarget into oPCTarget, go REDIR, taken counter +1. Not taken -> stay IDLE, not-taken counter +1.
  - IDLE, hazard -> stay IDLE, stall counter +1.
  - REDIR: oRedirect=oFlush=1 for exactly one cycle; ID contents ignored (wrong path, no evaluation, no counting, no stall); -> IDLE.
- Counters saturate at all-ones; no wrap.
- Non-branch opcodes in ID: no action.

## Timing
- Reset (async assert, sync release): state IDLE, oFlags=0, oRedirect=oFlush=0, oPCTarget=0, all counters 0; oStall=0 while in reset. Reset during REDIR aborts the redirect.
- Flag latency: ALU result in EX at cycle t visible on oFlags at t+1.
- Decision latency: branch evaluated at cycle t (no hazard) -> oRedirect at t+1.
- Stall: asserted same cycle as hazard; pipeline bubble in EX at t+1 removes the hazard, branch resolves at t+1 on updated flags, redirect at t+2.
- Simultaneous flag write and non-hazard branch (other accumulator) in one cycle: branch uses pre-edge flags for its accumulator; write still commits.
- oPCTarget holds its value after REDIR until next taken branch.

## Structure
- Opcode defines shared in the existing instruction define header; add flag bit indices (FLAG_CA..FLAG_NB) and opcode group macros there.
- One sub-module: branch_cond (combinational: opcode + 6 flags -> is_branch, is_cond, acc_sel, taken).
- Flag register, hazard detect, FSM, counters in branch_unit.

## Test plan
- Reset mid-REDIR: assert iReset_n=0 while oRedirect=1 -> all outputs 0 immediately, IDLE after release.
- ADDA 0x80+0x80 in EX, next cycle BACS target 0x05 in ID (no hazard) -> oFlags CA=1,ZA=1; oRedirect=1, oPCTarget=0x05 one cycle later; oTakenCnt=1.
- ANDB result 0x00 in EX while BBEQ target 0x2A in ID -> oStall=1 that cycle, oStallCnt=1; next cycle resolves taken, oRedirect with 0x2A following cycle.
- ORA result 0x7F in EX while BBMI in ID -> no stall; BBMI not taken on old NB=0; oNotTakenCnt=1; ORA leaves CA unchanged.
- JMP 0x3FF in ID followed by BAEQ in ID during REDIR -> single oRedirect to 0x3FF, BAEQ ignored, counts unchanged.
- Preload oNotTakenCnt to 0xFFFE via 0xFFFE not-taken branches, two more -> holds 0xFFFF.
